// File: rtl/spi_flash_responder.sv
// SPI mode-0 read-only flash emulator: READ (0x03) and JEDEC ID (0x9F)
// served from an on-chip byte memory, with SPI pins oversampled on clk.
module spi_flash_responder #(
    parameter int unsigned ADDR_W      = 20,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              underrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic ack_ok;

    logic [22:0]       rx_q, rx_d;
    logic [23:0]       tx_q, tx_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        cmd_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // A CS rise withdraws the request at once, so an ack in that cycle is dropped too
    assign mem_req_o = req_q & ~cs_rise;
    assign ack_ok    = mem_ack_i & mem_req_o;
    assign cmd_byte  = {rx_q[6:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) state_d = CMD;
                end
                CMD: begin
                    if (sclk_rise && cnt_q == 5'd7) begin
                        unique case (cmd_byte)
                            8'h03:   state_d = ADDR;
                            8'h9F:   state_d = ID;
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (sclk_rise && cnt_q == 5'd23) state_d = DATA;
                end
                DATA, ID, IGNORE: state_d = state_q;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q != IDLE);
    end

    always_comb begin
        rx_d       = rx_q;
        tx_d       = tx_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        req_d      = req_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        underrun_d = 1'b0;

        if (ack_ok) begin
            buf_d     = mem_rdata_i;
            buf_vld_d = 1'b1;
            req_d     = 1'b0;
        end

        if (cs_rise) begin
            rx_d      = '0;
            tx_d      = '0;
            cnt_d     = '0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
            req_d     = 1'b0;
            addr_d    = '0;
            buf_d     = '0;
            buf_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        cnt_d = '0;
                        rx_d  = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d  = {rx_q[21:0], mosi_s};
                        cnt_d = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
                        if (cnt_q == 5'd7 && cmd_byte == 8'h9F) tx_d = JEDEC_ID;
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[21:0], mosi_s};
                        if (cnt_q == 5'd23) begin
                            cnt_d  = '0;
                            addr_d = ADDR_W'({rx_q, mosi_s});
                            req_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
                        oe_d  = 1'b1;
                        if (cnt_q[2:0] == 3'd0) begin
                            // Byte boundary: consume prefetch and fetch the next byte
                            if (buf_vld_q) begin
                                miso_d    = buf_q[7];
                                tx_d      = {buf_q[6:0], 17'd0};
                                buf_vld_d = 1'b0;
                                addr_d    = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                                req_d     = 1'b1;
                            end else begin
                                miso_d     = 1'b1;
                                tx_d       = {7'h7F, 17'd0};
                                underrun_d = 1'b1;
                            end
                        end else begin
                            miso_d = tx_q[23];
                            tx_d   = {tx_q[22:0], 1'b0};
                        end
                    end
                end
                ID: begin
                    if (sclk_fall) begin
                        oe_d   = 1'b1;
                        miso_d = tx_q[23];
                        tx_d   = {tx_q[22:0], 1'b1};
                    end
                end
                IGNORE: oe_d = 1'b0;
                default: oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q       <= '0;
            tx_q       <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            underrun_q <= underrun_d;
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = oe_q;
    assign mem_addr_o    = addr_q;
    assign underrun_o    = underrun_q;

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI mode-0 target that emulates the read side of the configuration flash.
- Answers the bitstream loader's SPI master (READ 0x03, JEDEC ID 0x9F) from an on-chip byte memory through a req/ack port.
- Used in self-boot test setups and FPGA-in-loop benches in place of an external flash.
- SPI pins are oversampled in the single system clock domain.

Parameters:
ADDR_W, 20, memory address width; the 24-bit SPI address is truncated to its ADDR_W LSBs.
JEDEC_ID, 24'hEF4018, value returned by command 0x9F, MSB first.
SYNC_STAGES, 2, synchronizer depth on sclk, cs_n and mosi (allowed values 2 or 3).

Ports:
clk  in  1  system clock; must be at least 8x SCLK (each SCLK phase at least 4 clk periods).
rst_n  in  1  asynchronous active-low reset.
spi_sclk_i  in  1  SPI clock from the master.
spi_cs_n_i  in  1  chip select, active low.
spi_mosi_i  in  1  master-to-target data.
spi_miso_o  out  1  target-to-master data.
spi_miso_oe_o  out  1  MISO output enable for the pad.
mem_req_o  out  1  memory read request.
mem_addr_o  out  ADDR_W  memory byte address.
mem_ack_i  in  1  read data valid; one-cycle pulse.
mem_rdata_i  in  8  read data, sampled when mem_ack_i=1.
busy_o  out  1  high while CS is low (synchronized).
underrun_o  out  1  one-cycle pulse when a byte is needed before its memory data has arrived.

Behaviour:
- Reset (async assert, sync release): every output 0; FSM in IDLE; shift registers and counters 0.
- Inputs pass through SYNC_STAGES flops. Rising/falling SCLK edges are detected from the last two synced samples. Edges are ignored while synced cs_n=1.
- MOSI is sampled on the detected rising edge. MISO is updated on the detected falling edge. All data is MSB first.
- FSM states: IDLE, CMD, ADDR, DATA, ID, IGNORE.
- IDLE -> CMD on synced cs_n falling; bit counter cleared; busy_o=1.
- CMD: shift in 8 bits. On the 8th rising edge:
  - 0x03 -> ADDR.
  - 0x9F -> ID; load JEDEC_ID into a 24-bit output shift register.
  - any other value -> IGNORE.
- ADDR: shift in 24 bits. On the 24th rising edge, set mem_addr_o = addr[ADDR_W-1:0] and assert mem_req_o the next cycle. State -> DATA.
- DATA:
  - On each byte-boundary falling edge (the first one, then every 8th), load the prefetch buffer into the output shift register, drive bit7, and set miso_oe=1.
  - The same cycle, mem_addr_o increments (wraps at 2^ADDR_W) and a new request is issued for the next byte.
  - If the buffer is not yet valid at a load, load 8'hFF and pulse underrun_o. The pending request still completes, and its data is used for the following byte.
- Memory handshake:
  - mem_req_o stays high with mem_addr_o stable until mem_ack_i. It drops the cycle after ack. At most one request is outstanding.
  - mem_ack_i while mem_req_o=0 is ignored.
- ID: miso_oe=1 from the first falling edge. Shift JEDEC_ID out on successive falling edges. After 24 bits, drive 1s until CS deasserts.
- IGNORE: miso_oe=0; consume edges until CS deasserts.
- Synced cs_n rising, from any state (including mid-byte or mid-address):
  - next cycle: FSM -> IDLE; miso_oe=0; miso_o=0; busy_o=0.
  - mem_req_o is dropped immediately; a late ack for an abandoned request is discarded; prefetch buffer invalidated.
- A simultaneous cs_n rise and SCLK edge gives the CS rise priority.
- A new transaction always restarts at CMD. No state is retained across CS cycles.
- Async reset mid-transaction returns to reset values immediately. Bits already clocked by the master are lost.

Test Plan:
1. Memory preloaded with 0xA0,0xA1,0xA2,0xA3 at address 0x10; master sends 03 00 00 10 then 32 clocks; ack 1 cycle after req -> MISO bytes A0 A1 A2 A3, underrun_o never asserted, mem_addr_o sequence 0x10..0x14.
2. Master sends 9F then 32 clocks -> MISO EF 40 18 FF; mem_req_o never asserted.
3. Master sends 0x05 then 16 clocks -> miso_oe stays 0 throughout; busy_o high until CS rises.
4. READ at 0xFFFFF (ADDR_W=20), 2 bytes -> addresses 0xFFFFF then 0x00000 are requested.
5. Ack held off 40 cycles on the first byte -> first byte 0xFF with one underrun_o pulse; second byte equals mem[addr].
6. CS raised after 12 address bits, then a new READ at 0x10; separately, rst_n pulsed during DATA -> every output returns to 0 and the next READ returns correct data from byte 0.
